// File: rtl/tmem_responder_if.sv
// Bus between the CPU memory port and the tagged-memory responder.
// Signal names are from the responder's side: i_* flow into it and o_* flow back to the CPU.
interface tmem_responder_if;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb;
  logic        i_atomic;
  logic        i_rd;
  logic        i_wr;
  logic        i_wforce;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_ack;
  logic        o_wperr;
  logic        o_proterr;
  logic        o_busy;

  modport master (
    output i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
    input  o_data, o_tag, o_ack, o_wperr, o_proterr, o_busy
  );

  modport slave (
    input  i_ad, i_tag, i_astb, i_atomic, i_rd, i_wr, i_wforce,
    output o_data, o_tag, o_ack, o_wperr, o_proterr, o_busy
  );
endinterface

// File: rtl/tmem_responder.sv
// Tagged-memory responder: a word array of 64-bit data plus an 8-bit tag.
// It adds programmable wait states, tag-based write protection, an atomic
// read-then-write lock and protocol-error pulses.
//
//   state  | meaning
//   IDLE   | no address held, waiting for a strobe
//   ADDR   | address latched, waiting for a single rd or wr
//   WAITST | counting wait cycles before the acknowledge
//   ACK    | one-cycle acknowledge; read data shown, write committed
//   RECOV  | one-cycle turnaround; rd/wr ignored
//   LOCK   | atomic read done; a bare wr writes the locked word
//
// All outputs are forced low while reset is high, so an access cut off by
// reset never shows an ack.
module tmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          WAIT       = 0,
  parameter logic [7:0]  PROT_TAG   = 8'h3F
) (
  input logic        clk,
  input logic        reset,
  tmem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAITST,
    S_ACK,
    S_RECOV,
    S_LOCK
  } state_t;

  state_t                state, state_nx;
  logic [DEPTH_LOG2-1:0] addr, addr_nx;
  logic                  atomic_q, atomic_nx;
  logic                  is_wr, is_wr_nx;
  logic [3:0]            cnt, cnt_nx;
  logic [63:0]           rd_data;
  logic [7:0]            rd_tag;
  logic                  proterr;

  // Tag in bits [71:64], data in [63:0].
  logic [71:0]           mem [DEPTH];
  logic [71:0]           word;
  logic                  in_ack;
  logic                  prot_hit;
  logic                  do_write;

  assign word     = mem[addr];
  assign in_ack   = (state == S_ACK);
  // The check uses the tag stored before this write.
  assign prot_hit = (word[71:64] == PROT_TAG) && !bus.i_wforce;
  assign do_write = in_ack && is_wr && !prot_hit && !reset;

  // Next-state logic: strobe handling first, then per-state access flow.
  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    atomic_nx = atomic_q;
    is_wr_nx  = is_wr;
    cnt_nx    = cnt;
    proterr   = 1'b0;

    if (bus.i_astb && state != S_WAITST && state != S_ACK) begin
      // A strobe also abandons any held lock.
      state_nx  = S_ADDR;
      addr_nx   = bus.i_ad[DEPTH_LOG2-1:0];
      atomic_nx = bus.i_atomic;
    end else begin
      if (bus.i_astb) proterr = 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.i_rd || bus.i_wr) proterr = 1'b1;
        end
        S_ADDR: begin
          if (bus.i_rd && bus.i_wr) begin
            proterr = 1'b1;
          end else if (bus.i_rd || bus.i_wr) begin
            is_wr_nx = bus.i_wr;
            if (WAIT_CNT == 4'd0) begin
              state_nx = S_ACK;
            end else begin
              cnt_nx   = WAIT_CNT;
              state_nx = S_WAITST;
            end
          end
        end
        S_WAITST: begin
          cnt_nx = cnt - 4'd1;
          if (is_wr ? !bus.i_wr : !bus.i_rd) begin
            state_nx = S_ADDR;
          end else if (cnt == 4'd1) begin
            state_nx = S_ACK;
          end
        end
        S_ACK: begin
          state_nx = S_RECOV;
        end
        S_RECOV: begin
          state_nx = (atomic_q && !is_wr) ? S_LOCK : S_IDLE;
        end
        S_LOCK: begin
          if (bus.i_rd) begin
            proterr   = 1'b1;
            atomic_nx = 1'b0;
            state_nx  = S_IDLE;
          end else if (bus.i_wr) begin
            // Write half of the atomic pair goes straight to the access path
            // on the retained address; clearing atomic ends the lock at RECOV.
            is_wr_nx  = 1'b1;
            atomic_nx = 1'b0;
            if (WAIT_CNT == 4'd0) begin
              state_nx = S_ACK;
            end else begin
              cnt_nx   = WAIT_CNT;
              state_nx = S_WAITST;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Control registers and the held read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= '0;
      atomic_q <= 1'b0;
      is_wr    <= 1'b0;
      cnt      <= 4'd0;
      rd_data  <= 64'h0;
      rd_tag   <= 8'h00;
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      atomic_q <= atomic_nx;
      is_wr    <= is_wr_nx;
      cnt      <= cnt_nx;
      if (in_ack && !is_wr) begin
        rd_data <= word[63:0];
        rd_tag  <= word[71:64];
      end
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[addr] <= {bus.i_tag, bus.i_ad};
  end

  // Read data is shown directly on the ack cycle and held from the register afterwards.
  assign bus.o_data    = reset ? 64'h0 : ((in_ack && !is_wr) ? word[63:0]  : rd_data);
  assign bus.o_tag     = reset ? 8'h00 : ((in_ack && !is_wr) ? word[71:64] : rd_tag);
  assign bus.o_ack     = in_ack && !reset;
  assign bus.o_wperr   = in_ack && is_wr && prot_hit && !reset;
  assign bus.o_proterr = proterr && !reset;
  assign bus.o_busy    = !reset && (state == S_ADDR || state == S_WAITST ||
                                    state == S_ACK  || state == S_RECOV);

endmodule

// File: tb/tb_tmem_responder.sv
// Bench for tmem_responder: two instances (WAIT=0 and WAIT=3) share one driver.
// A transaction-level model predicts every output on every cycle.
module tb_tmem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tmem_responder_if b0();
  tmem_responder_if b3();

  tmem_responder #(.DEPTH_LOG2(10), .WAIT(0), .PROT_TAG(8'h3F)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  tmem_responder #(.DEPTH_LOG2(10), .WAIT(3), .PROT_TAG(8'h3F)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  // Driver state; sel picks which instance receives the stimulus.
  logic        sel = 1'b0, nxt_sel = 1'b0, nxt_rst = 1'b1;
  logic        d_astb = 0, d_atomic = 0, d_rd = 0, d_wr = 0, d_wf = 0;
  logic [63:0] d_ad = '0;
  logic [7:0]  d_tag = '0;

  assign b0.i_astb   = sel ? 1'b0 : d_astb;
  assign b0.i_atomic = sel ? 1'b0 : d_atomic;
  assign b0.i_rd     = sel ? 1'b0 : d_rd;
  assign b0.i_wr     = sel ? 1'b0 : d_wr;
  assign b0.i_wforce = sel ? 1'b0 : d_wf;
  assign b0.i_ad     = sel ? 64'h0 : d_ad;
  assign b0.i_tag    = sel ? 8'h0 : d_tag;
  assign b3.i_astb   = sel ? d_astb : 1'b0;
  assign b3.i_atomic = sel ? d_atomic : 1'b0;
  assign b3.i_rd     = sel ? d_rd : 1'b0;
  assign b3.i_wr     = sel ? d_wr : 1'b0;
  assign b3.i_wforce = sel ? d_wf : 1'b0;
  assign b3.i_ad     = sel ? d_ad : 64'h0;
  assign b3.i_tag    = sel ? d_tag : 8'h0;

  wire [63:0] s_data    = sel ? b3.o_data    : b0.o_data;
  wire [7:0]  s_tag     = sel ? b3.o_tag     : b0.o_tag;
  wire        s_ack     = sel ? b3.o_ack     : b0.o_ack;
  wire        s_wperr   = sel ? b3.o_wperr   : b0.o_wperr;
  wire        s_proterr = sel ? b3.o_proterr : b0.o_proterr;
  wire        s_busy    = sel ? b3.o_busy    : b0.o_busy;
  wire [3:0]  other_flags = sel ? {b0.o_busy, b0.o_ack, b0.o_proterr, b0.o_wperr}
                                : {b3.o_busy, b3.o_ack, b3.o_proterr, b3.o_wperr};

  // Model: expected flags for the current cycle, last read word, memory image.
  bit          e_ack, e_wperr, e_perr, e_busy;
  logic [63:0] last_d [2];
  logic [7:0]  last_t [2];
  logic [63:0] mdat [2][DEPTH];
  logic [7:0]  mtg  [2][DEPTH];
  bit          mval [2][DEPTH];
  bit          locked;
  int          lock_a;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [63:0] gd;
  logic [7:0]  gt;
  bit          gw;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 64'(s_ack), 64'(e_ack));
      check("wperr", 64'(s_wperr), 64'(e_wperr));
      check("proterr", 64'(s_proterr), 64'(e_perr));
      check("busy", 64'(s_busy), 64'(e_busy));
      check("data", s_data, reset ? 64'h0 : last_d[sel]);
      check("tag", 64'(s_tag), reset ? 64'h0 : 64'(last_t[sel]));
      check("other_idle", 64'(other_flags), 64'h0);
    end
  end

  // One bus cycle: apply inputs just after the rising edge and state what the outputs must be.
  task automatic drive(input bit astb, input bit atomic, input bit rd, input bit wr,
                       input logic [63:0] ad, input logic [7:0] tag, input bit wf,
                       input bit ack, input bit wperr, input bit perr, input bit busy);
    @(posedge clk);
    #1;
    reset = nxt_rst;
    sel = nxt_sel;
    d_astb = astb; d_atomic = atomic; d_rd = rd; d_wr = wr;
    d_ad = ad; d_tag = tag; d_wf = wf;
    e_ack = ack; e_wperr = wperr; e_perr = perr; e_busy = busy;
    if (nxt_rst) begin
      last_d[0] = '0; last_d[1] = '0; last_t[0] = '0; last_t[1] = '0;
      locked = 0;
    end
    chk_en = 1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    nxt_rst = 1;
    repeat (n) idle();
    nxt_rst = 0;
  endtask

  // Full strobed access; expected ack lands WAIT+1 cycles after rd/wr is seen.
  task automatic access(input logic [19:0] a20, input bit wr, input bit atomic,
                        input logic [63:0] d, input logic [7:0] t, input bit wf,
                        input bit both_err, input int abort_at, input bit inj, input bit hold,
                        output logic [63:0] rgd, output logic [7:0] rgt, output bit rgw);
    int w, a, k;
    bit prot, ab;
    w = sel ? 3 : 0;
    a = int'(a20) % DEPTH;
    ab = (abort_at > 0);
    drive(1, atomic, 0, 0, {32'($urandom), 12'($urandom), a20}, 8'h0, 0, 0, 0, 0, 0);
    if (both_err) drive(0, 0, 1, 1, d, t, wf, 0, 0, 1, 1);
    drive(0, 0, !wr, wr, d, t, wf, 0, 0, 0, 1);
    k = 1;
    while (k <= w) begin
      if (ab && k == abort_at) begin
        drive(0, 0, 0, 0, d, t, wf, 0, 0, 0, 1);
        drive(0, 0, !wr, wr, d, t, wf, 0, 0, 0, 1);
        ab = 0;
        k = 1;
      end else begin
        drive(inj, 0, !wr, wr, d, t, wf, 0, 0, inj, 1);
        k++;
      end
    end
    prot = wr && (mtg[sel][a] == 8'h3F) && !wf;
    drive(inj, 0, !wr, wr, d, t, wf, 1, prot, inj, 1);
    if (!wr) begin
      last_d[sel] = mdat[sel][a];
      last_t[sel] = mtg[sel][a];
    end else if (!prot) begin
      mdat[sel][a] = d;
      mtg[sel][a] = t;
      mval[sel][a] = 1;
    end
    @(negedge clk);
    rgd = s_data; rgt = s_tag; rgw = s_wperr;
    drive(0, 0, !wr && hold, wr && hold, d, t, wf, 0, 0, 0, 1);
    locked = atomic && !wr;
    lock_a = a;
  endtask

  // Write half of an atomic pair, issued from the lock without a strobe.
  task automatic lock_write(input logic [63:0] d, input logic [7:0] t, input bit wf, output bit rgw);
    int w;
    bit prot;
    w = sel ? 3 : 0;
    drive(0, 0, 0, 1, d, t, wf, 0, 0, 0, 0);
    for (int k = 1; k <= w; k++) drive(0, 0, 0, 1, d, t, wf, 0, 0, 0, 1);
    prot = (mtg[sel][lock_a] == 8'h3F) && !wf;
    drive(0, 0, 0, 1, d, t, wf, 1, prot, 0, 1);
    if (!prot) begin
      mdat[sel][lock_a] = d;
      mtg[sel][lock_a] = t;
    end
    @(negedge clk);
    rgw = s_wperr;
    drive(0, 0, 0, 0, d, t, wf, 0, 0, 0, 1);
    locked = 0;
  endtask

  task automatic rand_access();
    int a;
    logic [19:0] a20;
    bit wr, wf;
    logic [7:0] t;
    a = ($urandom_range(0, 11) * 83) % DEPTH;
    a20 = {10'($urandom), 10'(a)};
    wr = 1'($urandom_range(0, 1));
    wf = 1'($urandom_range(0, 1));
    if (!mval[sel][a]) begin
      wr = 1;
      wf = 1;
    end
    t = ($urandom_range(0, 3) == 0) ? 8'h3F : 8'($urandom);
    access(a20, wr, $urandom_range(0, 3) == 0, {$urandom, $urandom}, t, wf,
           $urandom_range(0, 5) == 0,
           (sel && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, gd, gt, gw);
  endtask

  task automatic rand_run(input int iters);
    int r;
    for (int it = 0; it < iters; it++) begin
      r = $urandom_range(0, 99);
      if (locked) begin
        if (r < 55) lock_write({$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)), gw);
        else if (r < 70) begin
          drive(0, 0, 1, 1'($urandom_range(0, 1)), 64'h0, 8'h0, 0, 0, 0, 1, 0);
          locked = 0;
        end else if (r < 80) idle();
        else rand_access();
      end else if (r < 10) begin
        repeat ($urandom_range(1, 3)) begin
          if ($urandom_range(0, 1) == 1) drive(0, 0, 1, 1'($urandom_range(0, 1)), 64'h0, 8'h0, 0, 0, 0, 1, 0);
          else drive(0, 0, 0, 1, 64'h0, 8'h0, 0, 0, 0, 1, 0);
        end
      end else begin
        rand_access();
      end
      repeat ($urandom_range(0, 2)) idle();
    end
    if (locked) begin
      drive(0, 0, 1, 0, 64'h0, 8'h0, 0, 0, 0, 1, 0);
      locked = 0;
    end
    idle();
  endtask

  initial begin
    locked = 0;
    do_reset(3);
    idle();

    // WAIT=0: write then read back address 5.
    access(20'd5, 1, 0, 64'h0123_4567_89AB_CDEF, 8'h12, 0, 0, 0, 0, 0, gd, gt, gw);
    check("wr5_wperr", 64'(gw), 64'h0);
    access(20'd5, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("rd5_data", gd, 64'h0123_4567_89AB_CDEF);
    check("rd5_tag", 64'(gt), 64'h12);

    // Protection on address 7, with rd+wr together in ADDR on the first write.
    access(20'd7, 1, 0, 64'hAAAA, 8'h3F, 1, 1, 0, 0, 0, gd, gt, gw);
    access(20'd7, 1, 0, 64'h1, 8'h00, 0, 0, 0, 0, 0, gd, gt, gw);
    check("prot_wperr", 64'(gw), 64'h1);
    access(20'd7, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("prot_unchanged", gd, 64'hAAAA);
    access(20'd7, 1, 0, 64'h1, 8'h00, 1, 0, 0, 0, 0, gd, gt, gw);
    check("force_wperr", 64'(gw), 64'h0);
    access(20'd7, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("force_data", gd, 64'h1);

    // Atomic read then bare write at address 9, then a stray bare write.
    access(20'd9, 1, 0, 64'h5, 8'h22, 1, 0, 0, 0, 0, gd, gt, gw);
    access(20'd9, 0, 1, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    lock_write(64'hFF, 8'h01, 0, gw);
    drive(0, 0, 0, 1, 64'h0, 8'h0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("stray_wr_perr", 64'(s_proterr), 64'h1);
    check("stray_wr_ack", 64'(s_ack), 64'h0);
    idle();
    access(20'd9, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("atomic_data", gd, 64'hFF);

    // Address 1024+3 aliases word 3.
    access(20'd1027, 1, 0, 64'hC0DE_0003, 8'h33, 1, 0, 0, 0, 0, gd, gt, gw);
    access(20'd3, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("alias_data", gd, 64'hC0DE_0003);

    rand_run(150);

    // WAIT=3 instance.
    nxt_sel = 1;
    idle();
    access(20'd5, 1, 0, 64'h5555_0000_0000_0005, 8'h05, 1, 0, 0, 0, 0, gd, gt, gw);
    access(20'd5, 0, 0, 64'h0, 8'h0, 0, 0, 2, 0, 0, gd, gt, gw);
    check("w3_abort_rd", gd, 64'h5555_0000_0000_0005);

    // Reset in the middle of a waited write leaves the word untouched.
    access(20'd20, 1, 0, 64'hA5A5_0000_1111_2222, 8'h44, 1, 0, 0, 0, 0, gd, gt, gw);
    drive(1, 0, 0, 0, 64'd20, 8'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 8'h55, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 8'h55, 1, 0, 0, 0, 1);
    nxt_rst = 1;
    drive(0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 8'h55, 1, 0, 0, 0, 0);
    nxt_rst = 0;
    @(negedge clk);
    check("rst_flags", 64'({s_ack, s_busy, s_wperr, s_proterr}), 64'h0);
    check("rst_data", s_data, 64'h0);
    idle();
    access(20'd20, 0, 0, 64'h0, 8'h0, 0, 0, 0, 0, 0, gd, gt, gw);
    check("rst_readback", gd, 64'hA5A5_0000_1111_2222);

    rand_run(150);

    @(posedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tmem_responder.md
Name: tmem_responder

Overview:
- Synthesizable responder for the CPU memory bus: o_ad, o_tag, o_astb, o_atomic, o_rd, o_wr, o_wforce out of the CPU; i_data, i_tag into the CPU.
- Sits at the far end of that bus in place of the behavioural tagged RAM. Holds a tagged word array (64-bit data plus 8-bit tag per word).
- Adds programmable wait states, tag-based write protection, an atomic read-modify-write lock, and protocol-error reporting.

Parameters:
- DEPTH_LOG2, 10, number of word-address bits decoded; the array has 2**DEPTH_LOG2 words. Higher address bits are ignored, so addresses wrap.
- WAIT, 0, extra wait cycles inserted before each acknowledge (0..15).
- PROT_TAG, 8'h3F, a stored tag equal to this value marks the word write-protected.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- i_ad  input  64  address/data from CPU; address in [19:0] during the strobe, write data during the write phase
- i_tag  input  8  write tag from CPU
- i_astb  input  1  address strobe
- i_atomic  input  1  read-modify-write flag, sampled with i_astb
- i_rd  input  1  read request (level)
- i_wr  input  1  write request (level)
- i_wforce  input  1  ignore write protection, sampled on the acknowledge cycle
- o_data  output  64  read data, returned to CPU i_data
- o_tag  output  8  read tag, returned to CPU i_tag
- o_ack  output  1  one-cycle completion pulse
- o_wperr  output  1  write suppressed by protection; pulses with o_ack
- o_proterr  output  1  one-cycle protocol-error pulse
- o_busy  output  1  access in progress

Behaviour:
- Reset: all outputs 0. State = IDLE. Address register 0, lock cleared, wait counter 0. The array is not cleared. Reset asserted mid-access aborts the access with no write and no ack.
- States: IDLE, ADDR, WAITST, ACK, RECOV, LOCK.
- i_astb in any state except WAITST/ACK: latch addr = i_ad[DEPTH_LOG2-1:0] and atomic flag = i_atomic, go to ADDR. This also drops any LOCK. i_astb in WAITST/ACK: ignored and o_proterr pulses.
- ADDR:
  - exactly one of i_rd/i_wr high: if WAIT=0 go to ACK, else load counter = WAIT and go to WAITST;
  - both high: o_proterr pulse, stay in ADDR, no access;
  - neither: stay.
- WAITST: decrement the counter; go to ACK in the cycle after it reaches 1. Latency is rd/wr sample cycle N -> o_ack at cycle N+1+WAIT. Dropping rd/wr during WAITST aborts: back to ADDR, no ack.
- ACK (o_ack=1 for exactly one cycle):
  - Read: o_data/o_tag = mem[addr]. The values are held stable until the next read ack.
  - Write: sample i_ad/i_tag/i_wforce. If stored tag == PROT_TAG and !i_wforce, the write is suppressed and o_wperr=1. Otherwise mem[addr] <= {i_tag, i_ad}.
- RECOV: one cycle; i_rd/i_wr are ignored (the master drops them here).
  - After an atomic read, go to LOCK with the address retained.
  - Otherwise go to IDLE; addr is retained but a new i_astb is required.
- LOCK: i_wr without i_astb performs the write phase on the locked address (ADDR path); lock clears at its ack. i_rd in LOCK: o_proterr pulse, lock cleared, go to IDLE.
- IDLE: i_rd or i_wr without i_astb gives an o_proterr pulse each cycle held; no access, no ack.
- o_busy = 1 in ADDR, WAITST, ACK, RECOV.
- Read-during-write: not possible, since only one access is ever in flight.
- Tag check uses the pre-write stored tag. A forced write may itself store PROT_TAG.

Test Plan:
- Write then read, WAIT=0: astb addr 5, wr data 64'h0123_4567_89AB_CDEF tag 8'h12 -> o_ack 1 cycle after wr. Then astb addr 5, rd -> o_data=0123_4567_89AB_CDEF, o_tag=12 on the ack cycle.
- WAIT=3: rd sampled at cycle N -> o_ack exactly at N+4. o_busy high from the cycle after astb through RECOV. Drop rd at N+2 -> no ack, state ADDR.
- Protection: store tag 8'h3F at addr 7, then wr 64'h1 without wforce -> o_wperr=1 with ack and the readback is unchanged. Repeat with wforce=1 -> o_wperr=0, readback 64'h1.
- Atomic: astb addr 9 atomic=1, rd -> ack; then wr 64'hFF without astb -> written to addr 9. A following wr without astb -> o_proterr, no ack.
- Errors and wrap: rd+wr together in ADDR -> o_proterr, no ack. Addr 1024+3 with DEPTH_LOG2=10 aliases addr 3.
- Reset mid-WAITST during a write -> all outputs 0, location unchanged on readback.
